dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data memory (byte/half/word access, combinational read, write on posedge). Requester 0 is the CPU load/store stage and requester 1 is the debug/DMA loader. Each requester uses a valid/ready request handshake. The block grants requesters round-robin, screens each request for misalignment, drives the memory port for exactly one cycle per access, and returns a registered one-cycle response pulse.

---
 rtl/dmem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer for the single-port data memory.
// Each accepted request takes IDLE -> ACCESS -> RESP, one cycle apiece.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wen,
  input  logic [1:0]        req0_type,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_sext,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wen,
  input  logic [1:0]        req1_type,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_sext,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,

  output logic              mem_wen,
  output logic [1:0]        mem_rwtype,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_sext,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic FIXED_PRIO_EN = (FIXED_PRIO != 0);

  state_t              state_r;
  state_t              state_nx_s;
  logic                last_grant_r;
  logic                grant_valid_s;
  logic                grant_id_s;
  logic                handshake_s;

  logic                wen_r;
  logic [1:0]          type_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                sext_r;
  logic                gid_r;

  logic                err_s;
  logic [DATA_W-1:0]   rdata_cap_s;

  // Byte accesses never fault; halves need even, words need 4-byte alignment.
  function automatic logic misaligned(input logic [1:0] ty, input logic [1:0] lsb);
    logic bad;
    case (ty)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lsb[0];
      2'b10:   bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign err_s       = misaligned(type_r, addr_r[1:0]);
  assign handshake_s = grant_valid_s & ~rst;
  assign rdata_cap_s = (~wen_r & ~err_s) ? mem_rdata : {DATA_W{1'b0}};

  // Arbitration: only meaningful in IDLE; ties go to the side that lost last time.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid_s = 1'b1;
        if (FIXED_PRIO_EN) begin
          grant_id_s = 1'b0;
        end else begin
          grant_id_s = ~last_grant_r;
        end
      end else if (req0_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end else if (req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = IDLE;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          state_nx_s = ACCESS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCESS:  state_nx_s = RESP;
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Request latch and round-robin history, captured on the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_r        <= 1'b0;
      type_r       <= 2'b00;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      sext_r       <= 1'b0;
      gid_r        <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (handshake_s) begin
      wen_r        <= grant_id_s ? req1_wen   : req0_wen;
      type_r       <= grant_id_s ? req1_type  : req0_type;
      addr_r       <= grant_id_s ? req1_addr  : req0_addr;
      wdata_r      <= grant_id_s ? req1_wdata : req0_wdata;
      sext_r       <= grant_id_s ? req1_sext  : req0_sext;
      gid_r        <= grant_id_s;
      last_grant_r <= grant_id_s;
    end else begin
      wen_r        <= wen_r;
      type_r       <= type_r;
      addr_r       <= addr_r;
      wdata_r      <= wdata_r;
      sext_r       <= sext_r;
      gid_r        <= gid_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Output decode: ready only in IDLE, write strobe only in ACCESS and never on a reset edge.
  always_comb begin
    req0_ready = handshake_s & ~grant_id_s;
    req1_ready = handshake_s &  grant_id_s;
    mem_rwtype = type_r;
    mem_addr   = addr_r;
    mem_wdata  = wdata_r;
    mem_sext   = sext_r;
    if (state_r == ACCESS) begin
      mem_wen = wen_r & ~err_s & ~rst;
    end else begin
      mem_wen = 1'b0;
    end
  end

  // Response pulse: loaded at the end of ACCESS, cleared every other cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_valid <= 1'b0;
      resp0_rdata <= {DATA_W{1'b0}};
      resp0_err   <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_rdata <= {DATA_W{1'b0}};
      resp1_err   <= 1'b0;
    end else if (state_r == ACCESS) begin
      resp0_valid <= ~gid_r;
      resp0_rdata <= gid_r ? {DATA_W{1'b0}} : rdata_cap_s;
      resp0_err   <= ~gid_r & err_s;
      resp1_valid <= gid_r;
      resp1_rdata <= gid_r ? rdata_cap_s : {DATA_W{1'b0}};
      resp1_err   <= gid_r & err_s;
    end else begin
      resp0_valid <= 1'b0;
      resp0_rdata <= {DATA_W{1'b0}};
      resp0_err   <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_rdata <= {DATA_W{1'b0}};
      resp1_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural byte memory behind the
// round-robin instance, plus a fixed-priority instance sharing the requests.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_wen, req0_sext;
  logic [1:0]  req0_type;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_wen, req1_sext;
  logic [1:0]  req1_type;
  logic [31:0] req1_addr, req1_wdata;

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic        mem_wen, mem_sext;
  logic [1:0]  mem_rwtype;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid;
  logic        fp_resp0_err, fp_resp1_err, fp_mem_wen, fp_mem_sext;
  logic [31:0] fp_resp0_rdata, fp_resp1_rdata, fp_mem_addr, fp_mem_wdata;
  logic [1:0]  fp_mem_rwtype;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int wen_cnt  = 0;

  logic [7:0] mbytes [0:255];
  logic [7:0] ra;
  logic [7:0] rb;
  logic [15:0] rh;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
    .req0_type(req0_type), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_sext(req0_sext), .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
    .req1_type(req1_type), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_sext(req1_sext), .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .resp1_err(resp1_err),
    .mem_wen(mem_wen), .mem_rwtype(mem_rwtype), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sext(mem_sext), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_wen(req0_wen),
    .req0_type(req0_type), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_sext(req0_sext), .resp0_valid(fp_resp0_valid), .resp0_rdata(fp_resp0_rdata),
    .resp0_err(fp_resp0_err),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_wen(req1_wen),
    .req1_type(req1_type), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_sext(req1_sext), .resp1_valid(fp_resp1_valid), .resp1_rdata(fp_resp1_rdata),
    .resp1_err(fp_resp1_err),
    .mem_wen(fp_mem_wen), .mem_rwtype(fp_mem_rwtype), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_sext(fp_mem_sext), .mem_rdata(32'h0000_0000)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory: combinational read, posedge write.
  assign ra = mem_addr[7:0];
  always_comb begin
    rb = mbytes[ra];
    rh = {mbytes[ra + 8'd1], mbytes[ra]};
    case (mem_rwtype)
      2'b00:   mem_rdata = mem_sext ? {{24{rb[7]}}, rb} : {24'h000000, rb};
      2'b01:   mem_rdata = mem_sext ? {{16{rh[15]}}, rh} : {16'h0000, rh};
      2'b10:   mem_rdata = {mbytes[ra + 8'd3], mbytes[ra + 8'd2], rh};
      default: mem_rdata = 32'h0000_0000;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wen) begin
      wen_cnt <= wen_cnt + 1;
      case (mem_rwtype)
        2'b00: mbytes[ra] <= mem_wdata[7:0];
        2'b01: begin
          mbytes[ra]        <= mem_wdata[7:0];
          mbytes[ra + 8'd1] <= mem_wdata[15:8];
        end
        2'b10: begin
          mbytes[ra]        <= mem_wdata[7:0];
          mbytes[ra + 8'd1] <= mem_wdata[15:8];
          mbytes[ra + 8'd2] <= mem_wdata[23:16];
          mbytes[ra + 8'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_req(input int n, input logic v, input logic wen, input logic [1:0] ty,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic sext);
    if (n == 0) begin
      req0_valid = v; req0_wen = wen; req0_type = ty;
      req0_addr = addr; req0_wdata = wdata; req0_sext = sext;
    end else begin
      req1_valid = v; req1_wen = wen; req1_type = ty;
      req1_addr = addr; req1_wdata = wdata; req1_sext = sext;
    end
  endtask

  // One full transaction from IDLE; returns at T+3, just after the edge.
  task automatic issue(input int n, input logic wen, input logic [1:0] ty,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic sext,
                       output logic [31:0] rdata, output logic err, output logic wen_seen);
    logic own_rdy, oth_rdy;
    set_req(n, 1'b1, wen, ty, addr, wdata, sext);
    @(negedge clk);
    own_rdy = (n == 0) ? req0_ready : req1_ready;
    oth_rdy = (n == 0) ? req1_ready : req0_ready;
    check("ready_in_idle", {31'd0, own_rdy}, 32'd1);
    check("other_ready_low", {31'd0, oth_rdy}, 32'd0);
    @(posedge clk); #1;
    set_req(n, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    wen_seen = mem_wen;
    check("no_resp_in_access", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    check("access_addr", mem_addr, addr);
    @(posedge clk); #1;
    @(negedge clk);
    check("wen_low_in_resp", {31'd0, mem_wen}, 32'd0);
    check("resp_valid_T2", {30'd0, resp1_valid, resp0_valid}, (n == 0) ? 32'd1 : 32'd2);
    rdata = (n == 0) ? resp0_rdata : resp1_rdata;
    err   = (n == 0) ? resp0_err : resp1_err;
    check("other_resp_quiet", (n == 0) ? {resp1_rdata[30:0], resp1_err} : {resp0_rdata[30:0], resp0_err}, 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er, ws;
  int          w0;
  int          gm[$];
  int          gf[$];

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem", {mem_wen, mem_sext, mem_rwtype} | mem_addr | mem_wdata, 32'd0);
    check("rst_resp", {resp0_valid, resp1_valid, resp0_err, resp1_err} | resp0_rdata | resp1_rdata, 32'd0);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;

    // Word store then word load.
    w0 = wen_cnt;
    issue(0, 1'b1, 2'b10, 32'h0400_4000, 32'hDEAD_BEEF, 1'b0, rd, er, ws);
    check("t1_store_wen", {31'd0, ws}, 32'd1);
    check("t1_store_rdata", rd, 32'd0);
    check("t1_wen_once", wen_cnt - w0, 32'd1);
    issue(0, 1'b0, 2'b10, 32'h0400_4000, 32'h0, 1'b0, rd, er, ws);
    check("t1_load_rdata", rd, 32'hDEAD_BEEF);
    check("t1_load_err", {31'd0, er}, 32'd0);
    check("t1_load_wen", {31'd0, ws}, 32'd0);

    // Byte store, then sign- and zero-extended byte loads.
    issue(0, 1'b1, 2'b00, 32'h0400_4003, 32'h0000_0080, 1'b0, rd, er, ws);
    issue(0, 1'b0, 2'b00, 32'h0400_4003, 32'h0, 1'b1, rd, er, ws);
    check("t2_sext", rd, 32'hFFFF_FF80);
    issue(0, 1'b0, 2'b00, 32'h0400_4003, 32'h0, 1'b0, rd, er, ws);
    check("t2_zext", rd, 32'h0000_0080);

    // Misaligned requests from requester 1 leave memory alone.
    w0 = wen_cnt;
    issue(1, 1'b1, 2'b01, 32'h0400_4001, 32'h0000_1234, 1'b0, rd, er, ws);
    check("t4_half_err", {31'd0, er}, 32'd1);
    check("t4_half_rdata", rd, 32'd0);
    check("t4_half_wen", {31'd0, ws}, 32'd0);
    issue(1, 1'b0, 2'b10, 32'h0400_4002, 32'h0, 1'b0, rd, er, ws);
    check("t4_word_err", {31'd0, er}, 32'd1);
    check("t4_word_rdata", rd, 32'd0);
    check("t4_no_writes", wen_cnt - w0, 32'd0);
    issue(1, 1'b0, 2'b10, 32'h0400_4000, 32'h0, 1'b0, rd, er, ws);
    check("t4_mem_unchanged", rd, 32'h80AD_BEEF);
    check("t4_reread_err", {31'd0, er}, 32'd0);

    // Illegal type; the next request must be ready at T+3 (checked inside issue).
    issue(0, 1'b0, 2'b11, 32'h0400_4000, 32'h0, 1'b0, rd, er, ws);
    check("t6_type11_err", {31'd0, er}, 32'd1);
    check("t6_type11_rdata", rd, 32'd0);
    issue(0, 1'b1, 2'b10, 32'h0400_4008, 32'hA5A5_A5A5, 1'b0, rd, er, ws);
    check("t6_next_ok_wen", {31'd0, ws}, 32'd1);

    // Reset during the ACCESS of a word store.
    set_req(0, 1'b1, 1'b1, 2'b10, 32'h0400_4008, 32'h1234_5678, 1'b0);
    @(negedge clk);
    check("t5_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_wen_blocked", {31'd0, mem_wen}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_outs_zero", mem_addr | mem_wdata | {30'd0, resp1_valid, resp0_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    @(posedge clk); #1;
    issue(0, 1'b0, 2'b10, 32'h0400_4008, 32'h0, 1'b0, rd, er, ws);
    check("t5_mem_kept", rd, 32'hA5A5_A5A5);
    issue(0, 1'b1, 2'b10, 32'h0400_4008, 32'h1234_5678, 1'b0, rd, er, ws);
    issue(1, 1'b0, 2'b10, 32'h0400_4008, 32'h0, 1'b0, rd, er, ws);
    check("t5_after_store", rd, 32'h1234_5678);

    // Both requesters valid continuously, from a fresh reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 2'b10, 32'h0400_4000, 32'h0, 1'b0);
    set_req(1, 1'b1, 1'b0, 2'b10, 32'h0400_4004, 32'h0, 1'b0);
    for (int c = 0; c < 40 && (gm.size() < 6 || gf.size() < 6); c++) begin
      @(negedge clk);
      check("t3_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (req0_ready) gm.push_back(0);
      if (req1_ready) gm.push_back(1);
      if (fp_req0_ready) gf.push_back(0);
      if (fp_req1_ready) gf.push_back(1);
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    check("t3_rr_count", gm.size(), 32'd6);
    check("t3_fp_count", gf.size(), 32'd6);
    for (int i = 0; i < 6 && i < gm.size(); i++) check("t3_rr_grant", gm[i], (i % 2 == 0) ? 32'd0 : 32'd1);
    for (int i = 0; i < 6 && i < gf.size(); i++) check("t3_fp_grant", gf[i], 32'd0);
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
